// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC, variable-latency imem handshake and the IF/ID register.
// Illegal fetch addresses never reach memory and deliver a NOP tagged with an AdEL flag.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter logic [31:0] IM_SIZE  = 32'h0000_4000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] npc,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] F_PC,
   output logic [31:0] D_PC,
   output logic [31:0] D_instr,
   output logic        D_exc,
   output logic        fetch_stall
);

   localparam logic [0:0] FETCH = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;

   // 33-bit end address so IM_BASE+IM_SIZE cannot wrap.
   localparam logic [32:0] IM_END = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

   logic [0:0]  state;
   logic [31:0] buf_instr;
   logic        buf_exc;

   logic        legal;
   logic        delivered;
   logic [31:0] src_word;
   logic        src_exc;

   assign legal = (F_PC[1:0] == 2'b00) && (F_PC >= IM_BASE) && ({1'b0, F_PC} < IM_END);

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      imem_req  = 1'b0;
      delivered = 1'b0;
      src_word  = 32'h0;
      src_exc   = 1'b0;
      if (state == FETCH) begin
         if (legal) begin
            imem_req  = reset;
            delivered = imem_ack && reset;
            src_word  = imem_rdata;
         end else begin
            delivered = 1'b1;
            src_exc   = 1'b1;
         end
      end
   end

   assign imem_addr   = F_PC;
   assign fetch_stall = (state == FETCH) && !delivered;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= FETCH;
         F_PC      <= RESET_PC;
         D_PC      <= 32'h0;
         D_instr   <= 32'h0;
         D_exc     <= 1'b0;
         buf_instr <= 32'h0;
         buf_exc   <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (delivered && !stall) begin
                  D_instr <= src_word;
                  D_exc   <= src_exc;
                  D_PC    <= F_PC;
                  F_PC    <= npc;
               end else if (delivered) begin
                  buf_instr <= src_word;
                  buf_exc   <= src_exc;
                  state     <= HOLD;
               end
            end
            default: begin
               // Word is parked; wait for D to accept it before fetching again.
               if (!stall) begin
                  D_instr <= buf_instr;
                  D_exc   <= buf_exc;
                  D_PC    <= F_PC;
                  F_PC    <= npc;
                  state   <= FETCH;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake latency, D-stage stall buffering,
// delay-slot timing, illegal-address exceptions and reset during an outstanding request.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] npc;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] F_PC;
   logic [31:0] D_PC;
   logic [31:0] D_instr;
   logic        D_exc;
   logic        fetch_stall;

   int tests  = 0;
   int failed = 0;

   fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .npc         (npc),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .F_PC        (F_PC),
      .D_PC        (D_PC),
      .D_instr     (D_instr),
      .D_exc       (D_exc),
      .fetch_stall (fetch_stall)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: a recognisable word per address.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return {16'hC0DE, addr[15:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic a, input logic [31:0] rd, input logic s, input logic [31:0] n);
      imem_ack   = a;
      imem_rdata = rd;
      stall      = s;
      npc        = n;
      #1;
   endtask

   // Single-cycle-ack fetch of pc with npc=nxt, no stall.
   task automatic fetch_ok(input logic [31:0] pc, input logic [31:0] nxt);
      drive(1'b1, mem_word(pc), 1'b0, nxt);
      check("req", {31'h0, imem_req}, 32'h1);
      check("addr", imem_addr, pc);
      check("fstall", {31'h0, fetch_stall}, 32'h0);
      cyc();
      check("D_PC", D_PC, pc);
      check("D_instr", D_instr, mem_word(pc));
      check("D_exc", {31'h0, D_exc}, 32'h0);
      check("F_PC", F_PC, nxt);
   endtask

   // Illegal fetch at pc: no request, zero-latency delivery of NOP+exc.
   task automatic fetch_bad(input logic [31:0] pc, input logic [31:0] nxt);
      drive(1'b0, 32'hDEAD_BEEF, 1'b0, nxt);
      check("bad_F_PC", F_PC, pc);
      check("bad_req", {31'h0, imem_req}, 32'h0);
      check("bad_fstall", {31'h0, fetch_stall}, 32'h0);
      cyc();
      check("bad_D_PC", D_PC, pc);
      check("bad_D_instr", D_instr, 32'h0);
      check("bad_D_exc", {31'h0, D_exc}, 32'h1);
      check("bad_F_PC_next", F_PC, nxt);
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      check("rst_req", {31'h0, imem_req}, 32'h0);
      cyc();
      check("rst_F_PC", F_PC, 32'h0000_3000);
      check("rst_D_PC", D_PC, 32'h0);
      check("rst_D_instr", D_instr, 32'h0);
      check("rst_D_exc", {31'h0, D_exc}, 32'h0);
      reset = 1'b1;

      fetch_ok(32'h3000, 32'h3004);

      // Three-cycle ack latency at 3004.
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 32'h0, 1'b0, 32'h3008);
         check("lat_req", {31'h0, imem_req}, 32'h1);
         check("lat_addr", imem_addr, 32'h3004);
         check("lat_fstall", {31'h0, fetch_stall}, 32'h1);
         cyc();
         check("lat_D_PC", D_PC, 32'h3000);
         check("lat_F_PC", F_PC, 32'h3004);
      end
      fetch_ok(32'h3004, 32'h3008);

      // Ack at 3008 while D is stalled: word parks in the hold buffer.
      drive(1'b1, mem_word(32'h3008), 1'b1, 32'h300C);
      check("stl_req", {31'h0, imem_req}, 32'h1);
      cyc();
      check("stl_D_PC", D_PC, 32'h3004);
      check("stl_F_PC", F_PC, 32'h3008);
      drive(1'b1, 32'hBAD0_BAD0, 1'b1, 32'h300C);
      check("hold_req", {31'h0, imem_req}, 32'h0);
      check("hold_fstall", {31'h0, fetch_stall}, 32'h0);
      cyc();
      check("hold_D_PC", D_PC, 32'h3004);
      check("hold_D_instr", D_instr, mem_word(32'h3004));
      drive(1'b0, 32'h0, 1'b0, 32'h300C);
      cyc();
      check("rel_D_PC", D_PC, 32'h3008);
      check("rel_D_instr", D_instr, mem_word(32'h3008));
      check("rel_F_PC", F_PC, 32'h300C);
      drive(1'b0, 32'h0, 1'b0, 32'h300C);
      check("rel_req", {31'h0, imem_req}, 32'h1);

      // Branch at 3010 in D when its delay slot 3014 is acked with npc=3100.
      fetch_ok(32'h300C, 32'h3010);
      fetch_ok(32'h3010, 32'h3014);
      fetch_ok(32'h3014, 32'h3100);

      // Misaligned, out-of-range (== end), last legal word, and below base.
      fetch_ok(32'h3100, 32'h3002);
      fetch_bad(32'h3002, 32'h3104);
      fetch_ok(32'h3104, 32'h7000);
      fetch_bad(32'h7000, 32'h6FFC);
      fetch_ok(32'h6FFC, 32'h2FFC);
      fetch_bad(32'h2FFC, 32'h3200);

      // Reset while the request at 3200 is outstanding; an ack lands in the reset cycle.
      drive(1'b0, 32'h0, 1'b0, 32'h3300);
      check("pre_rst_req", {31'h0, imem_req}, 32'h1);
      cyc();
      reset = 1'b0;
      drive(1'b1, mem_word(32'h3200), 1'b0, 32'h3300);
      check("mid_rst_req", {31'h0, imem_req}, 32'h0);
      cyc();
      check("mid_rst_F_PC", F_PC, 32'h3000);
      check("mid_rst_D_PC", D_PC, 32'h0);
      check("mid_rst_D_instr", D_instr, 32'h0);
      check("mid_rst_D_exc", {31'h0, D_exc}, 32'h0);
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 32'h3004);
      check("post_rst_req", {31'h0, imem_req}, 32'h1);
      check("post_rst_addr", imem_addr, 32'h3000);
      check("post_rst_fstall", {31'h0, fetch_stall}, 32'h1);
      cyc();
      check("post_rst_D_PC", D_PC, 32'h0);
      fetch_ok(32'h3000, 32'h3004);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
